// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and the default bit period
// used by both ends of the board-to-board link.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        CLEANUP
    } rx_state_t;

    // 50 MHz system clock at 9600 baud
    localparam int CLKS_PER_BIT_DEF = 5208;

endpackage

// File: rtl/receptor.sv
// UART 8N1 receive core: input synchroniser, bit-timing FSM, shift register and
// the held last-good-byte register.
//
// state   | meaning
// IDLE    | line idle, waiting for rx_s low
// START   | timing to mid start bit; reject if line went high again
// DATA    | sampling 8 data bits LSB-first at one bit period each
// STOP    | sampling stop bit; high = good byte, low = framing error
// CLEANUP | one cycle to drop o_Rx_Active before returning to IDLE
module receptor
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic       i_Clock,
    input  logic       i_Reset,
    input  logic       i_Rx_Serial,
    output logic       o_Rx_DV,
    output logic [7:0] o_Rx_Byte,
    output logic       o_Rx_Active,
    output logic       o_Rx_Error
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_C = CW'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CW-1:0] LAST_C = CW'(CLKS_PER_BIT - 1);

    logic            rx_meta, rx_s;
    rx_state_t       state, state_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic [2:0]      idx, idx_nxt;
    logic [7:0]      shift, shift_nxt;
    logic [7:0]      byte_nxt;
    logic            dv_nxt, err_nxt, active_nxt;

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= i_Rx_Serial;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            state       <= IDLE;
            cnt         <= '0;
            idx         <= 3'd0;
            shift       <= 8'h00;
            o_Rx_Byte   <= 8'h00;
            o_Rx_DV     <= 1'b0;
            o_Rx_Error  <= 1'b0;
            o_Rx_Active <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            idx         <= idx_nxt;
            shift       <= shift_nxt;
            o_Rx_Byte   <= byte_nxt;
            o_Rx_DV     <= dv_nxt;
            o_Rx_Error  <= err_nxt;
            o_Rx_Active <= active_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        idx_nxt    = idx;
        shift_nxt  = shift;
        byte_nxt   = o_Rx_Byte;
        dv_nxt     = 1'b0;
        err_nxt    = 1'b0;
        active_nxt = o_Rx_Active;
        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (!rx_s) state_nxt = START;
            end
            START: begin
                if (cnt == HALF_C) begin
                    cnt_nxt = '0;
                    if (!rx_s) begin
                        idx_nxt    = 3'd0;
                        active_nxt = 1'b1;
                        state_nxt  = DATA;
                    end else begin
                        state_nxt  = IDLE;
                    end
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            DATA: begin
                if (cnt == LAST_C) begin
                    cnt_nxt        = '0;
                    shift_nxt[idx] = rx_s;
                    if (idx == 3'd7) state_nxt = STOP;
                    else             idx_nxt   = idx + 3'd1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            STOP: begin
                if (cnt == LAST_C) begin
                    cnt_nxt = '0;
                    // a low stop bit leaves the held byte and displays untouched
                    if (rx_s) begin
                        byte_nxt = shift;
                        dv_nxt   = 1'b1;
                    end else begin
                        err_nxt  = 1'b1;
                    end
                    state_nxt = CLEANUP;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            CLEANUP: begin
                active_nxt = 1'b0;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: rtl/seven7.sv
// Hex nibble to seven-segment decoder, active-low segments ordered {g,f,e,d,c,b,a},
// matching the displays on the transmitter board.
module seven7 (
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    always_comb begin
        seg = 7'b1111111;
        case (hex)
            4'h0: seg = 7'b1000000;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0010000;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b0000011;
            4'hC: seg = 7'b1000110;
            4'hD: seg = 7'b0100001;
            4'hE: seg = 7'b0000110;
            4'hF: seg = 7'b0001110;
            default: seg = 7'b1111111;
        endcase
    end

endmodule

// File: rtl/uart_rx_display.sv
// UART receiver with the last good byte shown in hex on two seven-segment
// displays: high nibble on seg1, low nibble on seg2.
module uart_rx_display
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic       i_Clock,
    input  logic       i_Reset,
    input  logic       i_Rx_Serial,
    output logic       o_Rx_DV,
    output logic [7:0] o_Rx_Byte,
    output logic       o_Rx_Active,
    output logic       o_Rx_Error,
    output logic [6:0] seg1,
    output logic [6:0] seg2
);

    receptor #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_receptor (
        .i_Clock     (i_Clock),
        .i_Reset     (i_Reset),
        .i_Rx_Serial (i_Rx_Serial),
        .o_Rx_DV     (o_Rx_DV),
        .o_Rx_Byte   (o_Rx_Byte),
        .o_Rx_Active (o_Rx_Active),
        .o_Rx_Error  (o_Rx_Error)
    );

    seven7 u_seg_hi (.hex(o_Rx_Byte[7:4]), .seg(seg1));
    seven7 u_seg_lo (.hex(o_Rx_Byte[3:0]), .seg(seg2));

endmodule

// File: tb/tb_uart_rx_display.sv
// Scoreboard bench for uart_rx_display at 16 clocks per bit: each frame pushes
// its expected outcome and due cycle; a negedge monitor pops on every DV/Error.
module tb_uart_rx_display;

    localparam int CPB    = 16;
    localparam int HALF   = (CPB - 1) / 2;
    // line edge -> 2 sync flops -> IDLE detect, then start/data/stop timing, then registered pulse
    localparam int DV_LAT = 3 + (1 + HALF) + 9 * CPB;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic       dv, act, errp;
    logic [7:0] rx_byte;
    logic [6:0] seg1, seg2;

    uart_rx_display #(.CLKS_PER_BIT(CPB)) dut (
        .i_Clock     (clk),
        .i_Reset     (rst),
        .i_Rx_Serial (rx),
        .o_Rx_DV     (dv),
        .o_Rx_Byte   (rx_byte),
        .o_Rx_Active (act),
        .o_Rx_Error  (errp),
        .seg1        (seg1),
        .seg2        (seg2)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic       is_err;
        logic [7:0] data;
        int         due;
    } exp_t;

    exp_t       sb[$];
    exp_t       e_cur;
    int         n_cmp = 0;
    int         n_bad = 0;
    int         n_dv  = 0;
    int         n_erp = 0;
    logic [7:0] last_good = 8'h00;
    bit         watch_active = 1'b0;
    bit         saw_active   = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [6:0] seg_of(input logic [3:0] h);
        logic [6:0] s;
        case (h)
            4'h0: s = 7'h40; 4'h1: s = 7'h79; 4'h2: s = 7'h24; 4'h3: s = 7'h30;
            4'h4: s = 7'h19; 4'h5: s = 7'h12; 4'h6: s = 7'h02; 4'h7: s = 7'h78;
            4'h8: s = 7'h00; 4'h9: s = 7'h10; 4'hA: s = 7'h08; 4'hB: s = 7'h03;
            4'hC: s = 7'h46; 4'hD: s = 7'h21; 4'hE: s = 7'h06; default: s = 7'h0E;
        endcase
        return s;
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            if (watch_active && act) saw_active = 1'b1;
            if (dv || errp) begin
                if (dv)   n_dv++;
                if (errp) n_erp++;
                check_eq("dv_err_exclusive", {31'd0, dv & errp}, 32'd0);
                if (sb.size() == 0) begin
                    check_eq("unexpected_pulse", {30'd0, dv, errp}, 32'd0);
                end else begin
                    e_cur = sb.pop_front();
                    check_eq("pulse_kind", {30'd0, dv, errp}, e_cur.is_err ? 32'd1 : 32'd2);
                    check_eq("pulse_cycle", cyc, e_cur.due);
                    if (!e_cur.is_err) last_good = e_cur.data;
                    check_eq("rx_byte", {24'd0, rx_byte}, {24'd0, last_good});
                    check_eq("seg1", {25'd0, seg1}, {25'd0, seg_of(last_good[7:4])});
                    check_eq("seg2", {25'd0, seg2}, {25'd0, seg_of(last_good[3:0])});
                end
            end
        end
    end

    // Caller must be positioned #1 after a posedge; returns at the same phase.
    task automatic send_frame(input logic [7:0] d, input logic stop_bit);
        logic [9:0] bits;
        bits = {stop_bit, d, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx = bits[i];
            if (i == 0) sb.push_back('{~stop_bit, d, cyc + DV_LAT});
            repeat (CPB) @(posedge clk);
            #1;
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check_eq("reset_dv",     {31'd0, dv},      32'd0);
        check_eq("reset_err",    {31'd0, errp},    32'd0);
        check_eq("reset_active", {31'd0, act},     32'd0);
        check_eq("reset_byte",   {24'd0, rx_byte}, 32'h00);
        check_eq("reset_seg1",   {25'd0, seg1},    32'h40);
        check_eq("reset_seg2",   {25'd0, seg2},    32'h40);

        // single frame, probe Active mid-frame and after
        fork
            send_frame(8'hA5, 1'b1);
            begin
                repeat (80) @(posedge clk);
                #1 check_eq("a5_active_mid", {31'd0, act}, 32'd1);
            end
        join
        check_eq("a5_active_after", {31'd0, act},     32'd0);
        check_eq("a5_byte",         {24'd0, rx_byte}, 32'hA5);
        check_eq("a5_seg1",         {25'd0, seg1},    32'h08);
        check_eq("a5_seg2",         {25'd0, seg2},    32'h12);

        repeat (20) @(posedge clk);
        #1;
        send_frame(8'h3C, 1'b1);
        send_frame(8'hFF, 1'b1);
        repeat (20) @(posedge clk);
        #1;
        check_eq("b2b_byte", {24'd0, rx_byte}, 32'hFF);

        watch_active = 1'b1;
        rx = 1'b0;
        repeat (5) @(posedge clk);
        #1 rx = 1'b1;
        repeat (40) @(posedge clk);
        #1 watch_active = 1'b0;
        check_eq("glitch_active", {31'd0, saw_active}, 32'd0);
        check_eq("glitch_byte",   {24'd0, rx_byte},    32'hFF);

        send_frame(8'h81, 1'b0);
        rx = 1'b1;
        repeat (60) @(posedge clk);
        #1;
        check_eq("ferr_byte_kept", {24'd0, rx_byte}, 32'hFF);
        check_eq("ferr_seg1",      {25'd0, seg1},    32'h0E);

        // 8'h55 aborted by reset in the middle of bit 4
        rx = 1'b0;
        repeat (CPB) @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            #1 rx = (i % 2 == 0);
            repeat (CPB) @(posedge clk);
        end
        #1 rx = 1'b1;
        repeat (CPB / 2) @(posedge clk);
        #2;
        check_eq("pre_reset_active", {31'd0, act}, 32'd1);
        rst = 1'b1;
        #1;
        check_eq("mid_reset_active", {31'd0, act},     32'd0);
        check_eq("mid_reset_byte",   {24'd0, rx_byte}, 32'h00);
        check_eq("mid_reset_seg1",   {25'd0, seg1},    32'h40);
        check_eq("mid_reset_seg2",   {25'd0, seg2},    32'h40);
        check_eq("mid_reset_pulses", {30'd0, dv, errp}, 32'd0);
        last_good = 8'h00;
        repeat (4) @(posedge clk);
        #1 rst = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        send_frame(8'h12, 1'b1);
        repeat (20) @(posedge clk);
        #1;
        check_eq("post_reset_byte", {24'd0, rx_byte}, 32'h12);
        check_eq("post_reset_seg2", {25'd0, seg2},    32'h24);

        for (int i = 0; i < 400 && sb.size() != 0; i++) @(posedge clk);
        #1;
        check_eq("scoreboard_drained", sb.size(), 32'd0);
        check_eq("dv_count",           n_dv,      32'd4);
        check_eq("err_count",          n_erp,     32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
